// File: rtl/issue_scoreboard.sv
// Issue scheduler: register scoreboard with RAW/WAW hazard and unit-availability checks,
// combinational stall and one-hot issue strobe, serialised unit NUNIT-1 branches.
module issue_scoreboard #(
  parameter int NREG  = 64,
  parameter int NUNIT = 8,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     dec_valid,
  input  logic [$clog2(NUNIT)-1:0] dec_unit,
  input  logic [$clog2(NREG)-1:0]  dec_r1_rn,
  input  logic [$clog2(NREG)-1:0]  dec_r2_rn,
  input  logic [$clog2(NREG)-1:0]  dec_rd_rn,
  input  logic [$clog2(NREG)-1:0]  dec_rd2_rn,
  input  logic                     dec_wr_rd,
  input  logic                     dec_wr_rd2,
  input  logic [NUNIT-1:0]         unit_busy,
  input  logic                     wb0_valid,
  input  logic [$clog2(NREG)-1:0]  wb0_rn,
  input  logic                     wb1_valid,
  input  logic [$clog2(NREG)-1:0]  wb1_rn,
  input  logic                     redirect_done,
  input  logic                     flush,
  output logic                     stall,
  output logic [NUNIT-1:0]         issue,
  output logic [NREG-1:0]          sb_busy,
  output logic [1:0]               state,
  output logic [CNT_W-1:0]         stall_cycles
);

  localparam int RN_W   = $clog2(NREG);
  localparam int UNIT_W = $clog2(NUNIT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  state_e           state_q;
  logic [NREG-1:0]  sb_q, sb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic is_br;
  logic sb_empty;
  logic hazard;
  logic state_ok;
  logic can_issue;

  assign is_br    = (dec_unit == UNIT_W'(NUNIT - 1));
  assign sb_empty = (sb_q == '0);

  // sb_q[0] is never set, so r0 can never produce a hazard.
  assign hazard = sb_q[dec_r1_rn] | sb_q[dec_r2_rn]
                | (dec_wr_rd  & sb_q[dec_rd_rn])
                | (dec_wr_rd2 & sb_q[dec_rd2_rn]);

  // DRAIN only ever waits on the pending branch, so it may issue nothing else.
  assign state_ok = (state_q == RUN) | ((state_q == DRAIN) & is_br);

  assign can_issue = dec_valid & ~flush & ~hazard & ~unit_busy[dec_unit]
                   & state_ok & (~is_br | sb_empty);

  assign issue = can_issue ? (NUNIT'(1) << dec_unit) : '0;
  assign stall = (dec_valid & ~can_issue & ~flush) | (state_q == REDIRECT);

  always_comb begin
    sb_d = '0;
    for (int n = 1; n < NREG; n++) begin
      logic clr;
      logic set;
      clr = (wb0_valid & (wb0_rn == RN_W'(n))) | (wb1_valid & (wb1_rn == RN_W'(n)));
      set = can_issue & ((dec_wr_rd  & (dec_rd_rn  == RN_W'(n)))
                       | (dec_wr_rd2 & (dec_rd2_rn == RN_W'(n))));
      sb_d[n] = set | (sb_q[n] & ~clr);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else if (flush) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (can_issue && is_br)                    state_q <= REDIRECT;
          else if (dec_valid && is_br && !sb_empty)  state_q <= DRAIN;
        end
        DRAIN: begin
          if (can_issue) state_q <= REDIRECT;
        end
        REDIRECT: begin
          if (redirect_done) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign sb_busy      = sb_q;
  assign state        = state_q;
  assign stall_cycles = cnt_q;

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Issue scheduler between the decode stage and the eight execution units (unit field 0-7).
- Tracks pending register writes in a 64-entry scoreboard and checks RAW and WAW hazards and target-unit availability.
- Generates the combinational stall that freezes fetch/decode, and a one-hot issue strobe to the selected unit.
- Serialises unit-7 instructions (jumps/branches): waits for an empty scoreboard, then holds the pipe until the fetch redirect resolves.

Parameters:
NREG, 64, number of architectural registers; r0 is never tracked
NUNIT, 8, number of execution units; unit NUNIT-1 is the serialising branch unit
CNT_W, 32, width of the saturating stall-cycle counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
dec_valid  input  1  decode output register holds a valid instruction
dec_unit  input  3  unit field of decoded instruction
dec_r1_rn  input  6  first source register to check; 0 = none
dec_r2_rn  input  6  second source register to check; 0 = none
dec_rd_rn  input  6  primary destination
dec_rd2_rn  input  6  secondary destination
dec_wr_rd  input  1  instruction writes dec_rd_rn
dec_wr_rd2  input  1  instruction writes dec_rd2_rn
unit_busy  input  NUNIT  per-unit not-ready flag
wb0_valid  input  1  writeback port 0 retiring a write
wb0_rn  input  6  register retired on port 0
wb1_valid  input  1  writeback port 1 retiring a write
wb1_rn  input  6  register retired on port 1
redirect_done  input  1  one-cycle pulse: fetch has resolved the branch target
flush  input  1  discard the instruction currently in decode
stall  output  1  combinational; freezes fetch/decode
issue  output  NUNIT  combinational one-hot issue strobe
sb_busy  output  NREG  registered scoreboard, bit n = write to rn pending
state  output  2  FSM state for debug
stall_cycles  output  CNT_W  saturating count of cycles with stall=1

Behaviour:
- Reset (async, rst_n=0):
  - sb_busy = 0; state = RUN; stall_cycles = 0.
  - issue and stall evaluate to 0 while dec_valid is low.
- Hazard (combinational, uses the registered sb_busy only; no same-cycle writeback bypass, so a 1-cycle penalty is intended):
  - Asserted if sb_busy[dec_r1_rn] or sb_busy[dec_r2_rn].
  - Also asserted if (dec_wr_rd and sb_busy[dec_rd_rn]) or (dec_wr_rd2 and sb_busy[dec_rd2_rn]).
  - Register index 0 never causes a hazard.
- can_issue = dec_valid & ~flush & ~hazard & ~unit_busy[dec_unit] & state==RUN.
  - If dec_unit == NUNIT-1, can_issue additionally requires sb_busy == 0.
- Outputs:
  - issue = can_issue ? (1 << dec_unit) : 0.
  - stall = (dec_valid & ~can_issue & ~flush) | (state == REDIRECT).
  - flush never asserts stall, so decode advances past the discarded instruction.
- FSM, 2-bit encoding RUN=0, DRAIN=1, REDIRECT=2:
  - RUN: a valid unit-7 instruction with sb_busy != 0 -> DRAIN. Issue of a unit-7 instruction -> REDIRECT.
  - DRAIN: issue is blocked. When sb_busy == 0 and unit_busy[7] == 0, issue the branch this cycle (can_issue evaluated as if in RUN) -> REDIRECT. flush -> RUN.
  - REDIRECT: stall=1, no issue. redirect_done or flush -> RUN on the next edge.
  - flush has priority over every transition and always returns the FSM to RUN.
- Scoreboard update at posedge:
  - Clear the bit for wb0_rn if wb0_valid; clear the bit for wb1_rn if wb1_valid.
  - On issue, set the bits for dec_rd_rn (if dec_wr_rd) and dec_rd2_rn (if dec_wr_rd2).
  - If the same register is both set and cleared in one cycle, set wins.
  - Writes to r0 are never recorded.
  - wb0 and wb1 naming the same register clears it once; no error.
- flush does not clear sb_busy, because in-flight writes still retire.
- stall_cycles increments when stall=1 and saturates at all-ones (no wrap).
- Any issue strobe is at most one-hot; an all-zero strobe means no issue.

Test Plan:
- Reset mid-operation: set sb_busy[5] and state=REDIRECT, then pulse rst_n=0 -> sb_busy=0, state=0, stall_cycles=0 immediately, without waiting for a clock edge.
- RAW: issue unit 0 with rd=5, then next instruction with r1=5 -> stall=1, issue=0. Drive wb0_valid with rn=5 -> on the following cycle issue=8'h01, stall=0.
- Set-wins: an instruction writing rd=9 issues in the same cycle wb1 retires rn=9 -> sb_busy[9]=1 after the edge.
- Unit busy: unit_busy=8'h04, dec_unit=2, no hazards -> stall=1. Drop unit_busy -> issue=8'h04 in the same cycle.
- Branch serialise: sb_busy[3]=1 with a unit-7 instruction pending -> state DRAIN, stall=1. Retire r3 -> issue=8'h80 and state REDIRECT; stall stays 1 until redirect_done, then state=RUN.
- Flush and saturation:
  - flush in REDIRECT -> RUN next cycle, sb_busy unchanged.
  - Preload stall_cycles=32'hFFFFFFFE and stall for 3 cycles -> stall_cycles=32'hFFFFFFFF.
